// File: rtl/dcache_frame_reader.sv
// dcache_frame_reader: pops bytes from the audio dcache async FIFO read port and
// emits fixed-length frames (SYNC0, SYNC1, SEQ, payload, CKSUM) on a
// valid/ready byte stream. A FIFO that stays empty too long mid-payload
// causes the rest of the frame to be padded with zeros.
module dcache_frame_reader #(
  parameter int         PAYLOAD_LEN = 64,
  parameter logic [7:0] SYNC0       = 8'h55,
  parameter logic [7:0] SYNC1       = 8'hAA,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic       rd_clk,
  input  logic       rd_rst_n,
  input  logic       frame_en,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_rd_data,
  input  logic       fifo_rd_empty,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_eof,
  output logic       busy,
  output logic [7:0] seq_num,
  output logic       underrun_err
);

  localparam int CW  = $clog2(PAYLOAD_LEN + 1);
  localparam int ECW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    SEQ,
    PAYLOAD,
    CKSUM
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           pend;
  logic           pad_mode;
  logic [CW-1:0]  byte_cnt;
  logic [ECW-1:0] empty_cnt;
  logic [7:0]     cksum;

  logic           loadable;
  logic           eof_done;
  logic           pay_load;
  logic           last_byte;
  logic           empty_tick;
  logic           timeout_hit;
  logic           load_en;
  logic [7:0]     load_data;
  logic           load_sof;
  logic           load_eof;

  // Shared handshake and payload qualifiers used by the FSM and datapath.
  always_comb begin
    loadable    = !m_valid || m_ready;
    eof_done    = m_valid && m_ready && m_eof;
    pay_load    = (state == PAYLOAD) && (pend || (pad_mode && loadable));
    last_byte   = (byte_cnt == CW'(PAYLOAD_LEN - 1));
    empty_tick  = (state == PAYLOAD) && fifo_rd_empty && !pend && !pad_mode;
    timeout_hit = empty_tick && (empty_cnt == ECW'(TIMEOUT_CYC - 1));
  end

  // State register.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic; a frame only starts from IDLE, so frame_en cannot truncate one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_en && !fifo_rd_empty) state_nxt = HDR0;
      HDR0:    if (loadable) state_nxt = HDR1;
      HDR1:    if (loadable) state_nxt = SEQ;
      SEQ:     if (loadable) state_nxt = PAYLOAD;
      PAYLOAD: if (pay_load && last_byte) state_nxt = CKSUM;
      CKSUM:   if (eof_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: what to load into the output register and when to pop the FIFO.
  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = (state != IDLE);
    load_en    = 1'b0;
    load_data  = 8'h00;
    load_sof   = 1'b0;
    load_eof   = 1'b0;
    case (state)
      HDR0: begin
        load_en   = loadable;
        load_data = SYNC0;
        load_sof  = 1'b1;
      end
      HDR1: begin
        load_en   = loadable;
        load_data = SYNC1;
      end
      SEQ: begin
        load_en   = loadable;
        load_data = seq_num;
      end
      PAYLOAD: begin
        fifo_rd_en = !fifo_rd_empty && !pend && loadable && !pad_mode;
        load_en    = pay_load;
        load_data  = pend ? fifo_rd_data : 8'h00;
      end
      CKSUM: begin
        load_en   = loadable && !(m_valid && m_eof);
        load_data = cksum;
        load_eof  = 1'b1;
      end
      default: ;
    endcase
  end

  // One-entry output register: load when free or being drained, else hold.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (load_en) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_sof   <= load_sof;
      m_eof   <= load_eof;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
    end
  end

  // Read-pending flag: FIFO data arrives the cycle after the read strobe.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) pend <= 1'b0;
    else           pend <= fifo_rd_en;
  end

  // Payload bookkeeping: byte count, checksum, empty-cycle timeout and padding.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      byte_cnt     <= '0;
      empty_cnt    <= '0;
      cksum        <= 8'h00;
      pad_mode     <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      underrun_err <= timeout_hit;
      if (state == SEQ) begin
        byte_cnt  <= '0;
        empty_cnt <= '0;
        cksum     <= 8'h00;
        pad_mode  <= 1'b0;
      end else if (state == PAYLOAD) begin
        if (pay_load) byte_cnt <= byte_cnt + 1'b1;
        if (pend) cksum <= cksum + fifo_rd_data;
        if (fifo_rd_en)      empty_cnt <= '0;
        else if (empty_tick) empty_cnt <= empty_cnt + 1'b1;
        if (timeout_hit) pad_mode <= 1'b1;
      end else begin
        pad_mode <= 1'b0;
      end
    end
  end

  // Sequence number advances when the checksum byte is accepted.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)                     seq_num <= 8'h00;
    else if (state == CKSUM && eof_done) seq_num <= seq_num + 8'd1;
  end

endmodule
